buffered_io_port: RTL

- Parametrised successor to the single-register input/output port of the mini CPU data path.
- Input side: an external `strobe` captures `input_data` into an IN_DEPTH-entry FIFO. The CPU drains it one word per `InPortout` assertion onto the bus mux input.
- Output side: a registered output port loaded from the bus, with a valid/ack handshake toward the external consumer.
- Sits beside the bus mux in `data_path`, replacing the plain InPort/OutPort registers.

---
 rtl/io_port_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 52 +++++
 rtl/buffered_io_port.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/io_port_pkg.sv
// io_port_pkg: shared defaults and helpers for buffered_io_port.
//   DEFAULT_DATA_W      - bus / port width
//   DEFAULT_IN_DEPTH    - input FIFO entries (power of two, >= 2)
//   DEFAULT_SYNC_STAGES - synchroniser depth on the external strobe (>= 2)
//   cnt_w(depth)        - width of an occupancy count / wrapping pointer
package io_port_pkg;

  localparam int unsigned DEFAULT_DATA_W      = 32;
  localparam int unsigned DEFAULT_IN_DEPTH    = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchroniser chain followed by a rising-edge detector.
// Ports:
//   Clock      - system clock, rising edge
//   clear      - asynchronous active-low reset
//   async_in   - level input to be synchronised
//   rise_pulse - one-cycle pulse per rising edge of async_in
// With STAGES=1 the input is treated as already synchronous: the single flop
// holds the previous sample and the pulse is produced in the same cycle the
// input first reads high.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic Clock,
  input  logic clear,
  input  logic async_in,
  output logic rise_pulse
);

  if (STAGES == 1) begin : g_direct
    logic prev_q, prev_d;

    always_comb prev_d = async_in;

    always_ff @(posedge Clock or negedge clear) begin
      if (!clear) prev_q <= 1'b0;
      else        prev_q <= prev_d;
    end

    assign rise_pulse = async_in & ~prev_q;
  end else begin : g_sync
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
      prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        prev_q <= prev_d;
      end
    end

    assign rise_pulse = sync_q[STAGES-1] & ~prev_q;
  end

endmodule

// File: rtl/buffered_io_port.sv
// buffered_io_port: FIFO-buffered input port and handshaked output port for
// the mini CPU data path.
// Ports:
//   Clock, clear            - clock (rising edge), async active-low reset
//   strobe, input_data      - external capture request (async) and word
//   InPortout               - CPU pop request (one pop per rising edge)
//   BusMuxInInPortout       - FIFO head toward the bus mux (0 when empty)
//   in_empty/in_full/in_count - FIFO status
//   overrun, overrun_clr    - sticky dropped-push flag and its clear
//   BusOut, OutPortin       - bus word and output-register load
//   output_data, out_valid, out_ack - output port and consumer handshake
// Optional (macro IO_PORT_IRQ_EN): irq_mask in, irq out (registered).
module buffered_io_port
  import io_port_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned IN_DEPTH    = DEFAULT_IN_DEPTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                          Clock,
  input  logic                          clear,
  input  logic                          strobe,
  input  logic [DATA_W-1:0]             input_data,
  input  logic                          InPortout,
  output logic [DATA_W-1:0]             BusMuxInInPortout,
  output logic                          in_empty,
  output logic                          in_full,
  output logic [cnt_w(IN_DEPTH)-1:0]    in_count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  input  logic [DATA_W-1:0]             BusOut,
  input  logic                          OutPortin,
  output logic [DATA_W-1:0]             output_data,
  output logic                          out_valid,
`ifdef IO_PORT_IRQ_EN
  input  logic                          irq_mask,
  output logic                          irq,
`endif
  input  logic                          out_ack
);

  localparam int unsigned AW = $clog2(IN_DEPTH);
  localparam int unsigned CW = cnt_w(IN_DEPTH);

  logic              push_pulse, pop_pulse;
  logic              do_push, do_pop;
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] output_data_q, output_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] mem_q [IN_DEPTH];
  logic [DATA_W-1:0] mem_d [IN_DEPTH];

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_strobe_det (
    .Clock      (Clock),
    .clear      (clear),
    .async_in   (strobe),
    .rise_pulse (push_pulse)
  );

  sync_edge_detect #(.STAGES(1)) u_pop_det (
    .Clock      (Clock),
    .clear      (clear),
    .async_in   (InPortout),
    .rise_pulse (pop_pulse)
  );

  assign in_empty = (wr_ptr_q == rd_ptr_q);
  assign in_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_count = wr_ptr_q - rd_ptr_q;

  assign BusMuxInInPortout = in_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overrun           = overrun_q;
  assign output_data       = output_data_q;
  assign out_valid         = out_valid_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overrun_d     = overrun_q;
    mem_d         = mem_q;
    output_data_d = output_data_q;
    out_valid_d   = out_valid_q;

    // A pop on the same edge frees the slot, so a push into a full FIFO
    // still lands and is not an overrun.
    do_pop  = pop_pulse & ~in_empty;
    do_push = push_pulse & (~in_full | do_pop);

    if (do_pop) rd_ptr_d = rd_ptr_q + CW'(1);
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = input_data;
      wr_ptr_d                = wr_ptr_q + CW'(1);
    end

    if (push_pulse && !do_push) overrun_d = 1'b1;
    else if (overrun_clr)       overrun_d = 1'b0;

    if (OutPortin) begin
      output_data_d = BusOut;
      out_valid_d   = 1'b1;
    end else if (out_ack) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overrun_q     <= 1'b0;
      output_data_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overrun_q     <= overrun_d;
      output_data_q <= output_data_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Storage is not reset; contents are only visible through valid pointers.
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

`ifdef IO_PORT_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = (~in_empty | overrun_q) & ~irq_mask;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule
